// File: rtl/axi2s_regbank_mc.sv
// Multi-channel control/status register bank for the AXI-to-stream DMA path.
// Shadow BASE/SIZE/CTRL registers are copied to the active outputs on a
// frame_sync while a commit is armed. Also holds the deferred frame adjustment,
// sticky W1C error capture with a masked interrupt, and a registered read port.
module axi2s_regbank_mc #(
  parameter logic [17:0] BASE = 18'h00000,
  parameter int unsigned NCH  = 4,
  parameter int unsigned FW   = 24,
  parameter logic [31:0] VER  = 32'h0002_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wen,
  input  logic [17:0]       addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              rvalid,
  input  logic              frame_sync,
  output logic [NCH-1:0]    ch_en,
  output logic [NCH*32-1:0] ch_base,
  output logic [NCH*18-1:0] ch_size,
  input  logic [NCH*18-1:0] ch_acnt,
  input  logic [NCH*32-1:0] ch_bcnt,
  input  logic [NCH-1:0]    ch_err,
  output logic [FW-1:0]     frame_len,
  output logic [FW-1:0]     frame_adj,
  output logic              adj_pulse,
  output logic              adj_pending,
  output logic              irq
);

  // Channel c resets to 0xFFFC0000 + c * 0x10000.
  function automatic logic [NCH-1:0][31:0] base_rst();
    logic [NCH-1:0][31:0] v;
    for (int unsigned c = 0; c < NCH; c++) begin
      v[c] = 32'hFFFC_0000 + (32'(c) << 16);
    end
    return v;
  endfunction

  function automatic logic [NCH-1:0][17:0] size_rst();
    logic [NCH-1:0][17:0] v;
    for (int unsigned c = 0; c < NCH; c++) begin
      v[c] = 18'h400;
    end
    return v;
  endfunction

  // Address decode
  logic       hit, glob_sel, ch_sel, wr, rd;
  logic [2:0] reg_idx, ch_idx;
  logic [1:0] ch_fld;
  logic       unused_addr;

  assign hit         = (addr[17:8] == BASE[17:8]);
  assign glob_sel    = hit && (addr[7:5] == 3'b000);
  assign ch_sel      = hit && addr[7] && (32'(addr[6:4]) < NCH);
  assign reg_idx     = addr[4:2];
  assign ch_idx      = addr[6:4];
  assign ch_fld      = addr[3:2];
  assign wr          = en && wen;
  assign rd          = en && !wen;
  assign unused_addr = ^addr[1:0];

  logic wr_ctrl, wr_commit, wr_flen, wr_fadj, wr_err, wr_mask;
  assign wr_ctrl   = wr && glob_sel && (reg_idx == 3'd0);
  assign wr_commit = wr && glob_sel && (reg_idx == 3'd1);
  assign wr_flen   = wr && glob_sel && (reg_idx == 3'd2);
  assign wr_fadj   = wr && glob_sel && (reg_idx == 3'd3);
  assign wr_err    = wr && glob_sel && (reg_idx == 3'd4);
  assign wr_mask   = wr && glob_sel && (reg_idx == 3'd5);

  // State
  logic [NCH-1:0]       ctrl_sh_q, ctrl_sh_d, ch_en_q, ch_en_d;
  logic [NCH-1:0][31:0] base_sh_q, base_sh_d, base_act_q, base_act_d;
  logic [NCH-1:0][17:0] size_sh_q, size_sh_d, size_act_q, size_act_d;
  logic                 armed_q, armed_d;
  logic [FW-1:0]        frame_len_q, frame_len_d, frame_adj_q, frame_adj_d;
  logic                 adj_pending_q, adj_pending_d, adj_pulse_q, adj_pulse_d;
  logic [NCH-1:0]       err_q, err_d, irq_mask_q, irq_mask_d;
  logic                 irq_q, irq_d;
  logic [31:0]          dout_q, dout_d;
  logic                 rvalid_q, rvalid_d;

  logic commit_now;
  assign commit_now = frame_sync && armed_q;

  // Shadow writes, frame-synchronous commit and immediate disable
  always_comb begin
    ctrl_sh_d  = ctrl_sh_q;
    ch_en_d    = ch_en_q;
    base_sh_d  = base_sh_q;
    size_sh_d  = size_sh_q;
    base_act_d = base_act_q;
    size_act_d = size_act_q;
    // Commit copies the pre-edge shadows, so a coincident shadow write waits
    if (commit_now) begin
      ch_en_d    = ctrl_sh_q;
      base_act_d = base_sh_q;
      size_act_d = size_sh_q;
    end
    if (wr_ctrl) begin
      ctrl_sh_d = din[NCH-1:0];
      ch_en_d   = ch_en_d & din[NCH-1:0];
    end
    for (int unsigned c = 0; c < NCH; c++) begin
      if (wr && ch_sel && (ch_idx == 3'(c))) begin
        if (ch_fld == 2'd0) base_sh_d[c] = din;
        if (ch_fld == 2'd1) size_sh_d[c] = din[23:6];
      end
    end
  end

  // Commit arming, frame adjust, error capture and interrupt
  always_comb begin
    armed_d = armed_q;
    if (commit_now) armed_d = 1'b0;
    if (wr_commit && din[0]) armed_d = 1'b1;

    frame_len_d = wr_flen ? din[FW-1:0] : frame_len_q;

    frame_adj_d   = frame_adj_q;
    adj_pending_d = adj_pending_q;
    adj_pulse_d   = 1'b0;
    if (wr_fadj) begin
      // A write on the frame_sync edge re-arms instead of firing
      frame_adj_d   = din[FW-1:0];
      adj_pending_d = 1'b1;
    end else if (frame_sync && adj_pending_q) begin
      adj_pending_d = 1'b0;
      adj_pulse_d   = 1'b1;
    end

    err_d = err_q;
    if (wr_err) err_d = err_d & ~din[NCH-1:0];
    err_d = err_d | ch_err;

    irq_mask_d = wr_mask ? din[NCH-1:0] : irq_mask_q;
    irq_d      = |(err_q & irq_mask_q);
  end

  // Read data mux and registered read port
  logic [NCH-1:0][17:0] acnt_v;
  logic [NCH-1:0][31:0] bcnt_v;
  logic [31:0]          rdata;
  assign acnt_v = ch_acnt;
  assign bcnt_v = ch_bcnt;

  always_comb begin
    rdata = '0;
    if (glob_sel) begin
      case (reg_idx)
        3'd0:    rdata = 32'(ctrl_sh_q);
        3'd1:    rdata = {31'b0, armed_q};
        3'd2:    rdata = 32'(frame_len_q);
        3'd3:    rdata = 32'(frame_adj_q);
        3'd4:    rdata = 32'(err_q);
        3'd5:    rdata = 32'(irq_mask_q);
        3'd6:    rdata = {30'b0, armed_q, adj_pending_q};
        default: rdata = VER;
      endcase
    end
    for (int unsigned c = 0; c < NCH; c++) begin
      if (ch_sel && (ch_idx == 3'(c))) begin
        case (ch_fld)
          2'd0:    rdata = base_sh_q[c];
          2'd1:    rdata = {8'b0, size_sh_q[c], 6'b0};
          2'd2:    rdata = {8'b0, acnt_v[c], 6'b0};
          default: rdata = bcnt_v[c];
        endcase
      end
    end
    dout_d   = rd ? rdata : dout_q;
    rvalid_d = rd;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_sh_q     <= '0;
      ch_en_q       <= '0;
      base_sh_q     <= base_rst();
      base_act_q    <= base_rst();
      size_sh_q     <= size_rst();
      size_act_q    <= size_rst();
      armed_q       <= 1'b0;
      frame_len_q   <= FW'(1920);
      frame_adj_q   <= '0;
      adj_pending_q <= 1'b0;
      adj_pulse_q   <= 1'b0;
      err_q         <= '0;
      irq_mask_q    <= '0;
      irq_q         <= 1'b0;
      dout_q        <= '0;
      rvalid_q      <= 1'b0;
    end else begin
      ctrl_sh_q     <= ctrl_sh_d;
      ch_en_q       <= ch_en_d;
      base_sh_q     <= base_sh_d;
      base_act_q    <= base_act_d;
      size_sh_q     <= size_sh_d;
      size_act_q    <= size_act_d;
      armed_q       <= armed_d;
      frame_len_q   <= frame_len_d;
      frame_adj_q   <= frame_adj_d;
      adj_pending_q <= adj_pending_d;
      adj_pulse_q   <= adj_pulse_d;
      err_q         <= err_d;
      irq_mask_q    <= irq_mask_d;
      irq_q         <= irq_d;
      dout_q        <= dout_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign ch_en       = ch_en_q;
  assign ch_base     = base_act_q;
  assign ch_size     = size_act_q;
  assign frame_len   = frame_len_q;
  assign frame_adj   = frame_adj_q;
  assign adj_pulse   = adj_pulse_q;
  assign adj_pending = adj_pending_q;
  assign irq         = irq_q;
  assign dout        = dout_q;
  assign rvalid      = rvalid_q;

endmodule

// File: tb/tb_axi2s_regbank_mc.sv
// Self-checking bench for axi2s_regbank_mc (NCH=4, FW=24): a table of bus
// accesses followed by hand-written commit, adjust, error and reset sequences.
module tb_axi2s_regbank_mc;

  localparam int NCH = 4;
  localparam int FW  = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0, wen = 1'b0;
  logic [17:0]       addr = '0;
  logic [31:0]       din = '0;
  logic [31:0]       dout;
  logic              rvalid;
  logic              frame_sync = 1'b0;
  logic [NCH-1:0]    ch_en;
  logic [NCH*32-1:0] ch_base;
  logic [NCH*18-1:0] ch_size;
  logic [NCH*18-1:0] ch_acnt = '0;
  logic [NCH*32-1:0] ch_bcnt = '0;
  logic [NCH-1:0]    ch_err = '0;
  logic [FW-1:0]     frame_len, frame_adj;
  logic              adj_pulse, adj_pending, irq;

  axi2s_regbank_mc #(.BASE(18'h00000), .NCH(NCH), .FW(FW), .VER(32'h0002_0000)) dut (
    .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .din(din),
    .dout(dout), .rvalid(rvalid), .frame_sync(frame_sync), .ch_en(ch_en),
    .ch_base(ch_base), .ch_size(ch_size), .ch_acnt(ch_acnt), .ch_bcnt(ch_bcnt),
    .ch_err(ch_err), .frame_len(frame_len), .frame_adj(frame_adj),
    .adj_pulse(adj_pulse), .adj_pending(adj_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [17:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = a; din = d;
    @(negedge clk);
    en = 1'b0; wen = 1'b0;
  endtask

  task automatic bus_read(input logic [17:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    en = 1'b1; wen = 1'b0; addr = a;
    @(negedge clk);
    en = 1'b0;
    chk({name, " dout"}, 128'(dout), 128'(exp));
    chk({name, " rvalid"}, 128'(rvalid), 128'(1'b1));
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [17:0] addr;
    logic [31:0] data;  // write data, or expected read data
    string       name;
  } vec_t;

  vec_t vecs[$];
  logic [NCH*32-1:0] base_rst;
  logic [NCH*18-1:0] size_rst;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      base_rst[32*c +: 32] = 32'hFFFC_0000 + 32'(c) * 32'h1_0000;
      size_rst[18*c +: 18] = 18'h400;
    end
    ch_acnt[17:0]   = 18'h12345;
    ch_bcnt[127:96] = 32'hDEAD_BEEF;

    // SIZE reads report the size field at [23:6]: 0x400 << 6 = 0x10000
    vecs.push_back('{1'b0, 18'h080, 32'hFFFC_0000, "rd ch0 base"});
    vecs.push_back('{1'b0, 18'h084, 32'h0001_0000, "rd ch0 size"});
    vecs.push_back('{1'b0, 18'h0C0, 32'h0,         "rd ch4 oob"});
    vecs.push_back('{1'b0, 18'h090, 32'hFFFD_0000, "rd ch1 base"});
    vecs.push_back('{1'b0, 18'h0BC, 32'hDEAD_BEEF, "rd ch3 bcnt"});
    vecs.push_back('{1'b0, 18'h088, 32'h0048_D140, "rd ch0 acnt"});
    vecs.push_back('{1'b0, 18'h008, 32'd1920,      "rd frame_len"});
    vecs.push_back('{1'b0, 18'h01C, 32'h0002_0000, "rd version"});
    vecs.push_back('{1'b0, 18'h000, 32'h0,         "rd ctrl"});
    vecs.push_back('{1'b0, 18'h010, 32'h0,         "rd err"});
    vecs.push_back('{1'b1, 18'h014, 32'hA,         ""});
    vecs.push_back('{1'b0, 18'h014, 32'hA,         "rd mask"});
    vecs.push_back('{1'b1, 18'h114, 32'hF,         ""});
    vecs.push_back('{1'b0, 18'h014, 32'hA,         "rd mask after wrong page wr"});
    vecs.push_back('{1'b0, 18'h114, 32'h0,         "rd wrong page"});
    vecs.push_back('{1'b1, 18'h094, 32'h00AB_CDC0, ""});
    vecs.push_back('{1'b0, 18'h094, 32'h00AB_CDC0, "rd ch1 size"});
    vecs.push_back('{1'b1, 18'h0D4, 32'hFFFF_FFFF, ""});
    vecs.push_back('{1'b0, 18'h0D4, 32'h0,         "rd ch5 oob"});
    vecs.push_back('{1'b1, 18'h014, 32'h0,         ""});
    vecs.push_back('{1'b0, 18'h014, 32'h0,         "rd mask cleared"});
    vecs.push_back('{1'b1, 18'h008, 32'd100,       ""});
    vecs.push_back('{1'b0, 18'h008, 32'd100,       "rd frame_len wr"});
    vecs.push_back('{1'b1, 18'h020, 32'h55,        ""});
    vecs.push_back('{1'b0, 18'h020, 32'h0,         "rd unmapped"});

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst ch_en", 128'(ch_en), 128'(0));
    chk("rst ch_base", 128'(ch_base), 128'(base_rst));
    chk("rst ch_size", 128'(ch_size), 128'(size_rst));
    chk("rst frame_len", 128'(frame_len), 128'(1920));
    chk("rst adj", 128'({adj_pulse, adj_pending, frame_adj}), 128'(0));
    chk("rst irq/rvalid/dout", 128'({irq, rvalid, dout}), 128'(0));

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else bus_read(vecs[i].addr, vecs[i].data, vecs[i].name);
    end
    @(negedge clk);
    chk("rvalid drops, dout holds", 128'({rvalid, dout}), 128'({1'b0, 32'h0}));
    chk("frame_len out", 128'(frame_len), 128'(100));

    // Commit: shadows reach outputs only on frame_sync while armed
    bus_write(18'h090, 32'h1000_0000);
    bus_write(18'h000, 32'h2);
    bus_write(18'h004, 32'h1);
    chk("pre-commit base1", 128'(ch_base[63:32]), 128'(32'hFFFD_0000));
    chk("pre-commit ch_en", 128'(ch_en), 128'(0));
    bus_read(18'h004, 32'h1, "commit armed");
    bus_read(18'h018, 32'h2, "status armed");
    pulse_fs();
    chk("commit base1", 128'(ch_base[63:32]), 128'(32'h1000_0000));
    chk("commit ch_en", 128'(ch_en), 128'(4'b0010));
    chk("commit size1", 128'(ch_size[35:18]), 128'(18'h2AF37));
    bus_read(18'h004, 32'h0, "commit disarmed");

    // Disable is immediate
    bus_write(18'h000, 32'h0);
    chk("immediate disable", 128'(ch_en), 128'(0));

    // COMMIT write coinciding with frame_sync defers to the next frame_sync
    bus_write(18'h000, 32'h1);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = 18'h004; din = 32'h1; frame_sync = 1'b1;
    @(negedge clk);
    en = 1'b0; wen = 1'b0; frame_sync = 1'b0;
    chk("coincident commit deferred", 128'(ch_en), 128'(0));
    pulse_fs();
    chk("deferred commit applied", 128'(ch_en), 128'(4'b0001));

    // Shadow write on the committing edge is excluded from that commit
    bus_write(18'h004, 32'h1);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = 18'h000; din = 32'h3; frame_sync = 1'b1;
    @(negedge clk);
    en = 1'b0; wen = 1'b0; frame_sync = 1'b0;
    chk("shadow wr excluded", 128'(ch_en), 128'(4'b0001));
    bus_write(18'h004, 32'h1);
    pulse_fs();
    chk("shadow wr next commit", 128'(ch_en), 128'(4'b0011));

    // Frame adjust
    bus_write(18'h00C, 32'd5);
    chk("adj pending set", 128'({adj_pending, frame_adj}), 128'({1'b1, 24'd5}));
    bus_read(18'h018, 32'h1, "status pending");
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    chk("adj pulse", 128'({adj_pulse, adj_pending, frame_adj}), 128'({2'b10, 24'd5}));
    @(negedge clk);
    chk("adj pulse one cycle", 128'(adj_pulse), 128'(0));
    bus_write(18'h00C, 32'd7);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = 18'h00C; din = 32'd9; frame_sync = 1'b1;
    @(negedge clk);
    en = 1'b0; wen = 1'b0; frame_sync = 1'b0;
    chk("adj wr on fs", 128'({adj_pulse, adj_pending, frame_adj}), 128'({2'b01, 24'd9}));
    pulse_fs();
    chk("adj pulse after rewrite", 128'({adj_pulse, adj_pending, frame_adj}),
        128'({2'b10, 24'd9}));

    // Error capture and interrupt
    @(negedge clk);
    ch_err = 4'b0100;
    @(negedge clk);
    ch_err = 4'b0000;
    bus_write(18'h014, 32'h4);
    chk("irq lags mask", 128'(irq), 128'(0));
    @(negedge clk);
    chk("irq set", 128'(irq), 128'(1));
    bus_read(18'h010, 32'h4, "err sticky");
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = 18'h010; din = 32'h4; ch_err = 4'b0100;
    @(negedge clk);
    en = 1'b0; wen = 1'b0; ch_err = 4'b0000;
    bus_read(18'h010, 32'h4, "err set wins");
    bus_write(18'h010, 32'h4);
    chk("irq lags clear", 128'(irq), 128'(1));
    @(negedge clk);
    chk("irq cleared", 128'(irq), 128'(0));
    bus_read(18'h010, 32'h0, "err cleared");

    // Reset mid-commit with adjustment pending
    bus_write(18'h080, 32'h2000_0000);
    bus_write(18'h000, 32'hF);
    bus_write(18'h00C, 32'd3);
    bus_write(18'h004, 32'h1);
    bus_read(18'h018, 32'h3, "status before rst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst ch_en", 128'(ch_en), 128'(0));
    chk("mid rst ch_base", 128'(ch_base), 128'(base_rst));
    chk("mid rst ch_size", 128'(ch_size), 128'(size_rst));
    chk("mid rst adj", 128'({adj_pending, frame_adj}), 128'(0));
    chk("mid rst misc", 128'({irq, rvalid, dout, frame_len}), 128'({34'h0, 24'd1920}));
    @(negedge clk);
    rst = 1'b0;
    pulse_fs();
    chk("no commit after rst", 128'({ch_en, ch_base}), 128'({4'b0, base_rst}));
    chk("no adj after rst", 128'(adj_pulse), 128'(0));
    bus_read(18'h004, 32'h0, "armed after rst");
    bus_read(18'h080, 32'hFFFC_0000, "shadow after rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
